mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the pipelined MIPS core's instruction-fetch port and data-memory port onto one shared single-ported memory with a request/ready handshake. Sits between the datapath's IF/MEM stages and the unified memory. Generates per-port stall signals so the hazard logic can freeze the pipeline while an access is outstanding. Data accesses take priority over fetches, because the MEM-stage instruction is older.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ifReq  in  1  fetch request, held until ifValid
- ifAddr  in  ADDR_W  fetch address (the pc)
- ifData  out  DATA_W  fetched instruction, registered
- ifValid  out  1  one-cycle pulse: ifData valid, fetch complete
- ifStall  out  1  ifReq & ~ifValid (combinational)
- dReq  in  1  data access request, held until dValid
- dWrite  in  1  1 = store, 0 = load
- dAddr  in  ADDR_W  data address (aluOut)
- dWData  in  DATA_W  store data (writeData)
- dRData  out  DATA_W  load data, registered
- dValid  out  1  one-cycle pulse: data access complete
- dStall  out  1  dReq & ~dValid (combinational)
- memReq  out  1  memory request, registered
- memWe  out  1  memory write enable, registered
- memAddr  out  ADDR_W  memory address, registered
- memWData  out  DATA_W  memory write data, registered
- memReady  in  1  memory completes the current request this cycle
- memRData  in  DATA_W  memory read data, valid when memReady = 1

## Operation
The FSM has four states: IDLE, BUSY_I, BUSY_D, DONE.

- **IDLE**
  - If dReq = 1: latch dAddr, dWrite and dWData into memAddr, memWe and memWData. Set memReq = 1. Go to BUSY_D.
  - Else if ifReq = 1: latch ifAddr. Set memWe = 0 and memReq = 1. Go to BUSY_I.
  - Else stay in IDLE.
- **BUSY_I / BUSY_D**
  - memReq, memAddr, memWe and memWData are held constant.
  - When memReady = 1 on a rising edge:
    - Drop memReq and go to DONE.
    - BUSY_I: register memRData into ifData and assert ifValid.
    - BUSY_D read: register memRData into dRData and assert dValid.
    - BUSY_D write: assert dValid; dRData holds its previous value.
- **DONE**
  - Exactly one cycle; the valid pulse is visible here.
  - No arbitration in this cycle: the requester still shows its completed request while the pipeline advances.
  - Always go to IDLE.

Rules:
- Priority is fixed: data beats fetch whenever both are pending in IDLE.
- Fetch starvation is bounded by the pipeline, since a stalled MEM stage issues no new data requests.
- Request inputs are sampled only in IDLE. Changes to address or data while BUSY are ignored.
- If the requester drops ifReq or dReq while BUSY, the transaction still completes and the valid pulse still fires; the requester discards the result.
- Stalls:
  - ifStall is 1 in every cycle where ifReq = 1, except the ifValid cycle.
  - dStall follows the same rule with dReq and dValid.
  - A fetch waiting behind a data access therefore sees ifStall = 1 throughout.

## Timing
- Reset values:
  - state = IDLE
  - memReq = memWe = 0
  - memAddr = memWData = 0
  - ifData = dRData = 0
  - ifValid = dValid = 0
- Reset applied mid-transaction:
  - Next edge returns to IDLE with memReq = 0.
  - No valid pulse is issued.
  - The memory must tolerate an abandoned request.
- Latency, with the request seen in IDLE at cycle N:
  - memReq = 1 from cycle N+1.
  - The first possible memReady is sampled at the edge ending cycle N+1.
  - The valid pulse is in cycle N+2 at the earliest.
  - General case: memReady first seen high in cycle M gives valid in cycle M+1.
- Throughput: at most one access per 3 cycles (IDLE, BUSY, DONE).
- A memReady asserted while memReq = 0 is ignored.
- memReq never deasserts before memReady is seen.

## Test plan
- **Single fetch:** ifReq = 1, ifAddr = 0x0000_0040; memReady = 1 one cycle after memReq rises, memRData = 0x2008_0005.
  - memReq high for 1 cycle with memAddr = 0x40, memWe = 0.
  - ifValid pulses with ifData = 0x2008_0005.
  - ifStall = 1 for exactly 2 cycles.
- **Simultaneous requests:** ifReq = 1 and dReq = 1 (load, dAddr = 0x80) in the same IDLE cycle.
  - The data access is issued first.
  - dValid comes before the fetch starts.
  - The fetch is issued in the IDLE cycle after DONE.
  - ifStall stays 1 until ifValid.
- **Store:** dWrite = 1, dAddr = 0x54, dWData = 0xDEAD_BEEF, memReady delayed 3 cycles.
  - memWe = 1 with memAddr and memWData held stable for all 4 BUSY cycles.
  - dValid pulses once.
  - dRData is unchanged.
- **Wait states:** memReady held low for 5 cycles.
  - memReq, memAddr and memWe stay stable.
  - No valid pulse until the cycle after memReady = 1.
- **Reset mid-operation:** reset asserted in BUSY_D.
  - Next cycle: all outputs at reset values, state IDLE, no dValid.
  - After reset is released, a fresh fetch completes normally.
- **Request dropped:** ifReq deasserted during BUSY_I.
  - The transaction still completes and ifValid pulses once.
  - A subsequent dReq is served with no lost cycles beyond DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// Data accesses win over fetches; each access runs IDLE -> BUSY -> DONE.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifValid,
  output logic              ifStall,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dValid,
  output logic              dStall,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memRData
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state_reg, state_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] if_data_reg, if_data_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              if_valid_reg, if_valid_next;
  logic              d_valid_reg, d_valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_data_reg   <= '0;
      d_rdata_reg   <= '0;
      if_valid_reg  <= 1'b0;
      d_valid_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_data_reg   <= if_data_next;
      d_rdata_reg   <= d_rdata_next;
      if_valid_reg  <= if_valid_next;
      d_valid_reg   <= d_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_data_next   = if_data_reg;
    d_rdata_next   = d_rdata_reg;
    if_valid_next  = 1'b0;
    d_valid_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // The MEM-stage access is older than the fetch, so it goes first.
        if (dReq) begin
          mem_addr_next  = dAddr;
          mem_we_next    = dWrite;
          mem_wdata_next = dWData;
          mem_req_next   = 1'b1;
          state_next     = BUSY_D;
        end else if (ifReq) begin
          mem_addr_next = ifAddr;
          mem_we_next   = 1'b0;
          mem_req_next  = 1'b1;
          state_next    = BUSY_I;
        end
      end
      BUSY_I: begin
        if (memReady) begin
          mem_req_next  = 1'b0;
          if_data_next  = memRData;
          if_valid_next = 1'b1;
          state_next    = DONE;
        end
      end
      BUSY_D: begin
        if (memReady) begin
          mem_req_next = 1'b0;
          if (!mem_we_reg) begin
            d_rdata_next = memRData;
          end
          d_valid_next = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        // Requester still shows the finished request here; do not re-arbitrate.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign memReq   = mem_req_reg;
  assign memWe    = mem_we_reg;
  assign memAddr  = mem_addr_reg;
  assign memWData = mem_wdata_reg;
  assign ifData   = if_data_reg;
  assign dRData   = d_rdata_reg;
  assign ifValid  = if_valid_reg;
  assign dValid   = d_valid_reg;
  assign ifStall  = ifReq & ~if_valid_reg;
  assign dStall   = dReq & ~d_valid_reg;

endmodule
